// File: rtl/iob_eth_mem_arbiter.sv
// -----------------------------------------------------------------------------
// iob_eth_mem_arbiter
//
// Shares one IOb memory port between two IOb requesters:
//   port 0 : ethmac DMA (wishbone2iob output)
//   port 1 : CPU / system master
// Round-robin arbitration with one outstanding transaction. The winner's
// request fields are captured at grant and the memory port is driven from
// registers, so a requester may change or drop its request while the
// transaction is in flight. A watchdog aborts transactions the memory never
// acknowledges and reports them with r*_err.
//
// Parameters
//   ADDR_W     address width, requesters and memory port
//   DATA_W     data width; strobe width is DATA_W/8
//   TIMEOUT_W  watchdog counter width; 0 removes the watchdog
//
// Ports
//   clk                 system clock
//   rst_n_i             synchronous reset, active low
//   rN_valid            requester N request valid, fields stable until rN_ready
//   rN_addr/wdata/wstrb requester N request fields (wstrb == 0 means read)
//   rN_rdata            requester N read data, valid with rN_ready, 0 otherwise
//   rN_ready            requester N completion pulse (one cycle)
//   rN_err              with rN_ready: transaction aborted by the watchdog
//   m_valid             memory request valid
//   m_addr/wdata/wstrb  memory request fields, held for the whole transaction
//   m_rdata             memory read data, valid with m_ready
//   m_ready             memory completion pulse
// -----------------------------------------------------------------------------
module iob_eth_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n_i,

    input  logic                r0_valid,
    input  logic [ADDR_W-1:0]   r0_addr,
    input  logic [DATA_W-1:0]   r0_wdata,
    input  logic [DATA_W/8-1:0] r0_wstrb,
    output logic [DATA_W-1:0]   r0_rdata,
    output logic                r0_ready,
    output logic                r0_err,

    input  logic                r1_valid,
    input  logic [ADDR_W-1:0]   r1_addr,
    input  logic [DATA_W-1:0]   r1_wdata,
    input  logic [DATA_W/8-1:0] r1_wstrb,
    output logic [DATA_W-1:0]   r1_rdata,
    output logic                r1_ready,
    output logic                r1_err,

    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    localparam int STRB_W = DATA_W / 8;
    // Keep the counter at least one bit wide so the declaration stays legal
    // when the watchdog is removed; it is never incremented in that case.
    localparam int WD_W   = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              r_state;
    logic                r_gnt;        // port that owns the current transaction
    logic                r_last_gnt;   // port granted most recently
    logic [WD_W-1:0]     r_wd;         // cycles spent in BUSY without m_ready
    logic                r_m_valid;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [STRB_W-1:0]   r_m_wstrb;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic                w_any_req;
    logic                w_winner;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic [STRB_W-1:0]   w_win_wstrb;
    logic                w_busy;
    logic                w_wd_expired;
    logic                w_done_ok;
    logic                w_timeout;
    logic                w_done;

    // Winner selection. A lone requester always wins; on a tie the port that
    // was not granted last time goes first.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here by
        // direct assignment); a path that leaves one unassigned infers a latch.
        w_any_req = r0_valid | r1_valid;
        if (r0_valid && r1_valid) begin
            w_winner = ~r_last_gnt;
        end else begin
            w_winner = r1_valid;
        end
        w_win_addr  = w_winner ? r1_addr  : r0_addr;
        w_win_wdata = w_winner ? r1_wdata : r0_wdata;
        w_win_wstrb = w_winner ? r1_wstrb : r0_wstrb;
    end

    // Watchdog expiry: all-ones count means the final allowed cycle has come.
    generate
        if (TIMEOUT_W > 0) begin : g_wd
            assign w_wd_expired = (r_wd == {WD_W{1'b1}});
        end else begin : g_no_wd
            assign w_wd_expired = 1'b0;
        end
    endgenerate

    // Completion detection. A real m_ready takes priority over a timeout that
    // lands in the same cycle; m_ready outside BUSY is ignored.
    always_comb begin
        w_busy    = (r_state == S_BUSY);
        w_done_ok = w_busy & m_ready;
        w_timeout = w_busy & ~m_ready & w_wd_expired;
        w_done    = w_done_ok | w_timeout;
    end

    // Requester responses are combinational so the completion reaches the
    // owner in the same cycle as m_ready. Non-owners see all zeros.
    assign r0_ready = w_done    & ~r_gnt;
    assign r0_err   = w_timeout & ~r_gnt;
    assign r0_rdata = (w_done_ok && !r_gnt) ? m_rdata : '0;

    assign r1_ready = w_done    & r_gnt;
    assign r1_err   = w_timeout & r_gnt;
    assign r1_rdata = (w_done_ok && r_gnt) ? m_rdata : '0;

    assign m_valid  = r_m_valid;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_wstrb  = r_m_wstrb;

    // -------------------------------------------------------------------------
    // Arbitration FSM: IDLE -> BUSY -> IDLE, one bubble cycle in between.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of all others.
        if (!rst_n_i) begin
            // NOTE: the request field registers are reset too because they
            // drive module outputs directly and must read zero after reset.
            r_state    <= S_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_wd       <= '0;
            r_m_valid  <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_wstrb  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_m_valid  <= 1'b1;
                        r_m_addr   <= w_win_addr;
                        r_m_wdata  <= w_win_wdata;
                        r_m_wstrb  <= w_win_wstrb;
                        r_gnt      <= w_winner;
                        r_last_gnt <= w_winner;
                        r_wd       <= '0;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_done) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (TIMEOUT_W > 0) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
